// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters, with a one-entry response buffer per requester.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 first); the default is round-robin.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [3:0]       req0_ctrl_i,
    input  logic [WIDTH-1:0] req0_src1_i,
    input  logic [WIDTH-1:0] req0_src2_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [3:0]       req1_ctrl_i,
    input  logic [WIDTH-1:0] req1_src1_i,
    input  logic [WIDTH-1:0] req1_src2_i,

    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic [WIDTH-1:0] rsp0_result_o,
    output logic             rsp0_zero_o,
    output logic             rsp0_err_o,

    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [WIDTH-1:0] rsp1_result_o,
    output logic             rsp1_zero_o,
    output logic             rsp1_err_o,

    output logic [3:0]       alu_ctrl_o,
    output logic [WIDTH-1:0] alu_src1_o,
    output logic [WIDTH-1:0] alu_src2_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i
);

    localparam logic [3:0] CTRL_ADD = 4'b0010;

    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1010, 4'b1110, 4'b1111: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    logic elig0, elig1;
    logic grant0, grant1;
    logic last_grant;
    logic legal0, legal1;

    assign legal0 = is_legal(req0_ctrl_i);
    assign legal1 = is_legal(req1_ctrl_i);

    // A slot being drained this cycle can accept a new result, hence the ready term.
    assign elig0 = req0_valid_i & (~rsp0_valid_o | rsp0_ready_i);
    assign elig1 = req1_valid_i & (~rsp1_valid_o | rsp1_ready_i);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst_i) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0 = elig0;
            grant1 = elig1 & ~elig0;
`else
            if (elig0 && elig1) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
`endif
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Illegal codes and idle cycles park the ALU on a harmless add of zeros.
    always_comb begin
        alu_ctrl_o = CTRL_ADD;
        alu_src1_o = '0;
        alu_src2_o = '0;
        if (grant0 && legal0) begin
            alu_ctrl_o = req0_ctrl_i;
            alu_src1_o = req0_src1_i;
            alu_src2_o = req0_src2_i;
        end else if (grant1 && legal1) begin
            alu_ctrl_o = req1_ctrl_i;
            alu_src1_o = req1_src1_i;
            alu_src2_o = req1_src2_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant    <= 1'b1;
            rsp0_valid_o  <= 1'b0;
            rsp0_result_o <= '0;
            rsp0_zero_o   <= 1'b0;
            rsp0_err_o    <= 1'b0;
            rsp1_valid_o  <= 1'b0;
            rsp1_result_o <= '0;
            rsp1_zero_o   <= 1'b0;
            rsp1_err_o    <= 1'b0;
        end else begin
            if (grant0)
                last_grant <= 1'b0;
            else if (grant1)
                last_grant <= 1'b1;

            if (grant0) begin
                rsp0_valid_o  <= 1'b1;
                rsp0_result_o <= legal0 ? alu_result_i : '0;
                rsp0_zero_o   <= legal0 & alu_zero_i;
                rsp0_err_o    <= ~legal0;
            end else if (rsp0_ready_i) begin
                rsp0_valid_o  <= 1'b0;
            end

            if (grant1) begin
                rsp1_valid_o  <= 1'b1;
                rsp1_result_o <= legal1 ? alu_result_i : '0;
                rsp1_zero_o   <= legal1 & alu_zero_i;
                rsp1_err_o    <= ~legal1;
            end else if (rsp1_ready_i) begin
                rsp1_valid_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by random traffic, checked
// against a transaction-level model of grants and buffered responses.
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v    [2];
    logic [3:0]   ctrl [2];
    logic [W-1:0] s1   [2];
    logic [W-1:0] s2   [2];
    logic         rr   [2];

    logic         ready0, ready1;
    logic         rv0, rv1, rz0, rz1, re0, re1;
    logic [W-1:0] res0, res1;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_a, alu_b, alu_res;
    logic         alu_z;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state: what each response slot should hold, and who won last
    logic         m_valid [2];
    logic [W-1:0] m_res   [2];
    logic         m_zero  [2];
    logic         m_err   [2];
    int           m_last;
    logic         gexp    [2];
    logic         g       [2];

    logic [3:0]   legal_codes [8];

    always #5 clk = ~clk;

    function automatic logic legal(input logic [3:0] c);
        return c inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hA, 4'hE, 4'hF};
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (c)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h7:    return a ^ b;
            4'hA:    return a >> b[4:0];
            4'hE:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hF:    return a << b[4:0];
            default: return '0;
        endcase
    endfunction

    // behavioural ALU attached to the arbiter's ALU port
    assign alu_res = ref_alu(alu_ctrl, alu_a, alu_b);
    assign alu_z   = (alu_res == '0);

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v[0]), .req0_ready_o(ready0), .req0_ctrl_i(ctrl[0]),
        .req0_src1_i(s1[0]), .req0_src2_i(s2[0]),
        .req1_valid_i(v[1]), .req1_ready_o(ready1), .req1_ctrl_i(ctrl[1]),
        .req1_src1_i(s1[1]), .req1_src2_i(s2[1]),
        .rsp0_valid_o(rv0), .rsp0_ready_i(rr[0]), .rsp0_result_o(res0),
        .rsp0_zero_o(rz0), .rsp0_err_o(re0),
        .rsp1_valid_o(rv1), .rsp1_ready_i(rr[1]), .rsp1_result_o(res1),
        .rsp1_zero_o(rz1), .rsp1_err_o(re1),
        .alu_ctrl_o(alu_ctrl), .alu_src1_o(alu_a), .alu_src2_o(alu_b),
        .alu_result_i(alu_res), .alu_zero_i(alu_z)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already applied; covers one clock cycle.
    task automatic cycle();
        logic         e [2];
        int           win;
        logic [3:0]   ec;
        logic [W-1:0] ea, eb;
        #1;
        for (int k = 0; k < 2; k++) begin
            e[k]    = v[k] && (!m_valid[k] || rr[k]);
            gexp[k] = 1'b0;
        end
        win = -1;
        if (!rst) begin
            if (e[0] && e[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = (m_last == 0) ? 1 : 0;
`endif
            end else if (e[0]) win = 0;
            else if (e[1]) win = 1;
        end
        if (win >= 0) gexp[win] = 1'b1;
        ec = 4'h2; ea = '0; eb = '0;
        if (win >= 0 && legal(ctrl[win])) begin
            ec = ctrl[win]; ea = s1[win]; eb = s2[win];
        end
        g[0] = ready0;
        g[1] = ready1;
        chk("ready0", {31'd0, ready0}, {31'd0, gexp[0]});
        chk("ready1", {31'd0, ready1}, {31'd0, gexp[1]});
        chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ec});
        chk("alu_src1", alu_a, ea);
        chk("alu_src2", alu_b, eb);

        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = 1'b0; m_res[k] = '0; m_zero[k] = 1'b0; m_err[k] = 1'b0;
            end
            m_last = 1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (gexp[k]) begin
                    m_valid[k] = 1'b1;
                    m_err[k]   = !legal(ctrl[k]);
                    m_res[k]   = m_err[k] ? '0 : ref_alu(ctrl[k], s1[k], s2[k]);
                    m_zero[k]  = !m_err[k] && (m_res[k] == '0);
                end else if (rr[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            if (win >= 0) m_last = win;
        end

        @(negedge clk);
        chk("rsp0_valid", {31'd0, rv0}, {31'd0, m_valid[0]});
        chk("rsp1_valid", {31'd0, rv1}, {31'd0, m_valid[1]});
        chk("rsp0_result", res0, m_res[0]);
        chk("rsp1_result", res1, m_res[1]);
        chk("rsp0_zero", {31'd0, rz0}, {31'd0, m_zero[0]});
        chk("rsp1_zero", {31'd0, rz1}, {31'd0, m_zero[1]});
        chk("rsp0_err", {31'd0, re0}, {31'd0, m_err[0]});
        chk("rsp1_err", {31'd0, re1}, {31'd0, m_err[1]});
    endtask

    task automatic set_req(input int k, input logic val, input logic [3:0] c,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        v[k] = val; ctrl[k] = c; s1[k] = a; s2[k] = b;
    endtask

    initial begin
        legal_codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hA, 4'hE, 4'hF};
        for (int k = 0; k < 2; k++) begin
            set_req(k, 1'b0, 4'h0, '0, '0);
            rr[k] = 1'b1;
            m_valid[k] = 1'b0; m_res[k] = '0; m_zero[k] = 1'b0; m_err[k] = 1'b0;
        end
        m_last = 1;
        @(negedge clk);

        // reset, including combinational outputs while requests are present
        rst = 1'b1;
        set_req(0, 1'b1, 4'h2, 32'd1, 32'd2);
        set_req(1, 1'b1, 4'h2, 32'd3, 32'd4);
        cycle();
        cycle();
        rst = 1'b0;

        // conflict with both responses always drained
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, 4'h2, i, 32'd1);
            set_req(1, 1'b1, 4'h1, i, 32'd8);
            cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("conflict_g0", {31'd0, g[0]}, 32'd1);
`else
            chk("conflict_g0", {31'd0, g[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
`endif
        end
        set_req(1, 1'b0, 4'h0, '0, '0);

        // single operation 5 + 7
        set_req(0, 1'b1, 4'h2, 32'd5, 32'd7);
        cycle();
        chk("single_ready0", {31'd0, g[0]}, 32'd1);
        chk("single_result", res0, 32'd12);
        chk("single_zero", {31'd0, rz0}, 32'd0);
        set_req(0, 1'b0, 4'h0, '0, '0);
        cycle();

        // illegal control code, response left pending
        rr[0] = 1'b0;
        set_req(0, 1'b1, 4'h3, 32'd3, 32'd4);
        cycle();
        chk("illegal_err", {31'd0, re0}, 32'd1);
        chk("illegal_result", res0, 32'd0);

        // capture together with drain: xor 0xF0 ^ 0xFF
        rr[0] = 1'b1;
        set_req(0, 1'b1, 4'h7, 32'hF0, 32'hFF);
        cycle();
        chk("drain_valid", {31'd0, rv0}, 32'd1);
        chk("drain_result", res0, 32'h0F);
        set_req(0, 1'b0, 4'h0, '0, '0);
        cycle();

        // backpressure on response 1 after sub 9-9
        rr[1] = 1'b0;
        set_req(1, 1'b1, 4'h6, 32'd9, 32'd9);
        cycle();
        chk("bp_zero", {31'd0, rz1}, 32'd1);
        set_req(1, 1'b1, 4'h2, 32'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 4'h0, 32'hFFFF, i);
            cycle();
            chk("bp_g0", {31'd0, g[0]}, 32'd1);
            chk("bp_hold", res1, 32'd0);
        end
        rr[1] = 1'b1;
        cycle();
        chk("bp_release_g1", {31'd0, g[1]}, 32'd1);
        chk("bp_release_res", res1, 32'd2);

        // reset while both responses are valid
        rr[0] = 1'b0; rr[1] = 1'b0;
        set_req(0, 1'b1, 4'h2, 32'd10, 32'd10);
        set_req(1, 1'b1, 4'h2, 32'd20, 32'd20);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_valid0", {31'd0, rv0}, 32'd0);
        rst = 1'b0;
        rr[0] = 1'b1; rr[1] = 1'b1;
        cycle();
        chk("rst_first_conflict", {31'd0, g[0]}, 32'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++) begin
                v[k]    = ($urandom_range(0, 3) != 0);
                ctrl[k] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                      : legal_codes[$urandom_range(0, 7)];
                s1[k]   = $urandom_range(0, 1) ? W'($urandom_range(0, 15)) : W'($urandom);
                s2[k]   = $urandom_range(0, 1) ? W'($urandom_range(0, 15)) : W'($urandom);
                rr[k]   = ($urandom_range(0, 2) != 0);
            end
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
